// File: rtl/cpu_regfile.sv
// cpu_regfile: parametrised register file with NRD registered read ports, one
// write port, optional write-to-read bypass, optional hardwired-zero r0, and a
// clear sequencer that zeroes every entry after reset (the array has no reset).
module cpu_regfile #(
    parameter int unsigned DW      = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NRD*$clog2(DEPTH)-1:0]  rsel,
    input  logic                          ren,
    output logic [NRD*DW-1:0]             rdata,
    input  logic [$clog2(DEPTH)-1:0]      wsel,
    input  logic                          wreg,
    input  logic [DW-1:0]                 wdata,
    output logic                          busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra bit so the clear counter can never wrap at DEPTH = 256.
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // Storage: plain array without reset so it can map onto RAM or LUTs.
    logic [DW-1:0] mem [DEPTH];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          w_clr_we;
    logic          w_usr_we;
    logic          w_rd_load;
    logic          w_wr_r0;

    logic [AW-1:0] w_rsel   [NRD];
    logic [DW-1:0] w_rd_val [NRD];
    logic [DW-1:0] r_rdata  [NRD];

    assign busy    = r_busy;
    assign w_wr_r0 = (ZERO_R0 != 0) && (wsel == '0);

    // State register: reset forces a fresh clear pass from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: sweep the array in CLEAR, then serve reads/writes in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_clr_we    = 1'b0;
        w_usr_we    = 1'b0;
        w_rd_load   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we  = 1'b1;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(DEPTH - 1)) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_usr_we  = wreg && !w_wr_r0;
                w_rd_load = ren;
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    // Single write port shared by the clear sweep and user writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we) begin
                mem[r_cnt[AW-1:0]] <= '0;
            end else if (w_usr_we) begin
                mem[wsel] <= wdata;
            end
        end
    end

    for (genvar g = 0; g < int'(NRD); g++) begin : g_port
        assign w_rsel[g] = rsel[g*AW +: AW];

        // Per-port read mux: zero register wins, then bypass, then stored data.
        always_comb begin
            w_rd_val[g] = mem[w_rsel[g]];
            if ((BYPASS != 0) && wreg && (wsel == w_rsel[g])) begin
                w_rd_val[g] = wdata;
            end
            if ((ZERO_R0 != 0) && (w_rsel[g] == '0)) begin
                w_rd_val[g] = '0;
            end
        end

        assign rdata[g*DW +: DW] = r_rdata[g];
    end

    // Read registers: load all ports on ren in RUN, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NRD); i++) begin
                r_rdata[i] <= '0;
            end
        end else if (w_rd_load) begin
            for (int i = 0; i < int'(NRD); i++) begin
                r_rdata[i] <= w_rd_val[i];
            end
        end
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Bench for cpu_regfile: instances A (defaults), B (ZERO_R0=1, BYPASS=0) share
// stimulus; instance C (DEPTH=16, NRD=3, DW=32) covers the mid-clear reset.
module tb_cpu_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ab_reset, ab_ren, ab_wreg;
    logic [5:0]  ab_rsel;
    logic [2:0]  ab_wsel;
    logic [15:0] ab_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_busy, b_busy;

    logic        c_reset, c_ren, c_wreg;
    logic [11:0] c_rsel;
    logic [3:0]  c_wsel;
    logic [31:0] c_wdata;
    logic [95:0] c_rdata;
    logic        c_busy;

    cpu_regfile #(.DW(16), .DEPTH(8), .NRD(2), .ZERO_R0(0), .BYPASS(1)) u_a (
        .clk(clk), .reset(ab_reset), .rsel(ab_rsel), .ren(ab_ren), .rdata(a_rdata),
        .wsel(ab_wsel), .wreg(ab_wreg), .wdata(ab_wdata), .busy(a_busy)
    );

    cpu_regfile #(.DW(16), .DEPTH(8), .NRD(2), .ZERO_R0(1), .BYPASS(0)) u_b (
        .clk(clk), .reset(ab_reset), .rsel(ab_rsel), .ren(ab_ren), .rdata(b_rdata),
        .wsel(ab_wsel), .wreg(ab_wreg), .wdata(ab_wdata), .busy(b_busy)
    );

    cpu_regfile #(.DW(32), .DEPTH(16), .NRD(3), .ZERO_R0(0), .BYPASS(1)) u_c (
        .clk(clk), .reset(c_reset), .rsel(c_rsel), .ren(c_ren), .rdata(c_rdata),
        .wsel(c_wsel), .wreg(c_wreg), .wdata(c_wdata), .busy(c_busy)
    );

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        tests_run++;
        assert (obs_v === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs_v, exp_v);
        end
    endtask

    // src: 0/1 = A ports, 10/11 = B ports, 20..22 = C ports.
    function automatic logic [31:0] obs(input int src);
        case (src)
            0:       return {16'h0, a_rdata[15:0]};
            1:       return {16'h0, a_rdata[31:16]};
            10:      return {16'h0, b_rdata[15:0]};
            11:      return {16'h0, b_rdata[31:16]};
            20:      return c_rdata[31:0];
            21:      return c_rdata[63:32];
            22:      return c_rdata[95:64];
            default: return 32'hDEAD_0000;
        endcase
    endfunction

    task automatic push(input string tag, input int src, input logic [31:0] e);
        sb_t item;
        item.tag = tag;
        item.src = src;
        item.exp = e;
        sb.push_back(item);
    endtask

    // Advance one edge, then retire every expectation queued for that edge.
    task automatic step();
        sb_t item;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            chk(item.tag, obs(item.src), item.exp);
        end
    endtask

    // Count edges until busy drops, bounded so a stuck sequencer still finishes.
    task automatic count_busy(input int which, output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            n++;
            if (!((which == 0) ? a_busy : c_busy)) break;
        end
    endtask

    task automatic ab_expect(input string tag, input logic [15:0] ea0, input logic [15:0] ea1,
                             input logic [15:0] eb0, input logic [15:0] eb1);
        push({tag, "_a0"}, 0,  {16'h0, ea0});
        push({tag, "_a1"}, 1,  {16'h0, ea1});
        push({tag, "_b0"}, 10, {16'h0, eb0});
        push({tag, "_b1"}, 11, {16'h0, eb1});
    endtask

    task automatic ab_read(input string tag, input logic [2:0] p0, input logic [2:0] p1,
                           input logic [15:0] ea0, input logic [15:0] ea1,
                           input logic [15:0] eb0, input logic [15:0] eb1);
        ab_rsel = {p1, p0};
        ab_ren  = 1'b1;
        ab_expect(tag, ea0, ea1, eb0, eb1);
    endtask

    task automatic ab_write(input logic [2:0] a, input logic [15:0] d);
        ab_wreg  = 1'b1;
        ab_wsel  = a;
        ab_wdata = d;
        step();
        ab_wreg  = 1'b0;
    endtask

    task automatic c_write(input logic [3:0] a, input logic [31:0] d);
        c_wreg  = 1'b1;
        c_wsel  = a;
        c_wdata = d;
        step();
        c_wreg  = 1'b0;
    endtask

    task automatic c_read(input string tag, input logic [3:0] p0, input logic [3:0] p1,
                          input logic [3:0] p2, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2);
        c_rsel = {p2, p1, p0};
        c_ren  = 1'b1;
        push({tag, "_c0"}, 20, e0);
        push({tag, "_c1"}, 21, e1);
        push({tag, "_c2"}, 22, e2);
    endtask

    initial begin
        int n;
        ab_reset = 1'b1; ab_ren = 1'b0; ab_wreg = 1'b0;
        ab_rsel  = '0;   ab_wsel = '0;  ab_wdata = '0;
        c_reset  = 1'b1; c_ren  = 1'b0; c_wreg  = 1'b0;
        c_rsel   = '0;   c_wsel = '0;   c_wdata = '0;
        step();
        step();

        // Reset state
        chk("a_reset_busy", {31'h0, a_busy}, 32'h1);
        chk("b_reset_busy", {31'h0, b_busy}, 32'h1);
        chk("c_reset_busy", {31'h0, c_busy}, 32'h1);
        chk("a_reset_rdata", a_rdata, 32'h0);
        chk("b_reset_rdata", b_rdata, 32'h0);
        chk("c_reset_rdata0", obs(20), 32'h0);

        // Initial clear of A/B
        ab_reset = 1'b0;
        count_busy(0, n);
        chk("ab_clear_len", n, 32'd8);
        chk("b_busy_done", {31'h0, b_busy}, 32'h0);

        // Preload every entry, confirm it landed
        for (int i = 0; i < 8; i++) ab_write(3'(i), 16'(16'hA000 + i));
        ab_read("preload", 3'd3, 3'd7, 16'hA003, 16'hA007, 16'hA003, 16'hA007);
        step();
        ab_ren = 1'b0;

        // Reset pulse; writes and reads during busy must be ignored
        ab_reset = 1'b1;
        step();
        chk("a_pulse_busy", {31'h0, a_busy}, 32'h1);
        chk("a_pulse_rdata", a_rdata, 32'h0);
        chk("b_pulse_rdata", b_rdata, 32'h0);
        ab_reset = 1'b0;
        ab_wreg  = 1'b1; ab_wsel = 3'd3; ab_wdata = 16'h5555;
        ab_ren   = 1'b1; ab_rsel = {3'd7, 3'd3};
        count_busy(0, n);
        ab_wreg = 1'b0;
        ab_ren  = 1'b0;
        chk("ab_reclear_len", n, 32'd8);
        chk("a_busy_rdata_zero", a_rdata, 32'h0);

        // Every entry reads back zero after the clear
        for (int i = 0; i < 8; i++) begin
            ab_read("cleared", 3'(i), 3'((i + 1) % 8), 16'h0, 16'h0, 16'h0, 16'h0);
            step();
        end
        ab_ren = 1'b0;

        // Basic write then dual-port read
        ab_write(3'd3, 16'hBEEF);
        ab_write(3'd5, 16'h1234);
        ab_read("basic", 3'd5, 3'd3, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF);
        step();
        ab_ren = 1'b0;

        // Write/read collision: A forwards, B returns old data
        ab_write(3'd2, 16'h1111);
        ab_wreg = 1'b1; ab_wsel = 3'd2; ab_wdata = 16'h2222;
        ab_read("collide", 3'd2, 3'd2, 16'h2222, 16'h2222, 16'h1111, 16'h1111);
        step();
        ab_wreg = 1'b0;
        ab_read("after_collide", 3'd2, 3'd2, 16'h2222, 16'h2222, 16'h2222, 16'h2222);
        step();

        // Write and read of different addresses do not interact
        ab_wreg = 1'b1; ab_wsel = 3'd6; ab_wdata = 16'h6666;
        ab_read("disjoint", 3'd5, 3'd3, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF);
        step();
        ab_wreg = 1'b0;
        ab_read("disjoint_rd", 3'd6, 3'd6, 16'h6666, 16'h6666, 16'h6666, 16'h6666);
        step();
        ab_ren = 1'b0;

        // Register 0: normal in A, hardwired zero (no forwarding) in B
        ab_write(3'd0, 16'hFFFF);
        ab_read("r0_read", 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0);
        step();
        ab_wreg = 1'b1; ab_wsel = 3'd0; ab_wdata = 16'h7777;
        ab_read("r0_fwd", 3'd0, 3'd5, 16'h7777, 16'h1234, 16'h0, 16'h1234);
        step();
        ab_wreg = 1'b0;
        ab_ren  = 1'b0;

        // Hold: output keeps old data until ren returns
        ab_write(3'd4, 16'h00AA);
        ab_read("hold_load", 3'd4, 3'd3, 16'h00AA, 16'hBEEF, 16'h00AA, 16'hBEEF);
        step();
        ab_ren  = 1'b0;
        ab_wreg = 1'b1; ab_wsel = 3'd4; ab_wdata = 16'h00BB;
        ab_expect("hold_w", 16'h00AA, 16'hBEEF, 16'h00AA, 16'hBEEF);
        step();
        ab_wreg = 1'b0;
        ab_expect("hold_idle", 16'h00AA, 16'hBEEF, 16'h00AA, 16'hBEEF);
        step();
        ab_read("hold_reread", 3'd4, 3'd3, 16'h00BB, 16'hBEEF, 16'h00BB, 16'hBEEF);
        step();
        ab_ren = 1'b0;

        // Instance C: full clear, preload, then reset in the middle of a re-clear
        c_reset = 1'b0;
        count_busy(1, n);
        chk("c_clear_len", n, 32'd16);
        c_write(4'd9,  32'hDEADBEEF);
        c_write(4'd15, 32'hCAFEF00D);
        c_write(4'd0,  32'h00000001);
        c_reset = 1'b1;
        step();
        c_reset = 1'b0;
        repeat (5) step();
        chk("c_busy_mid", {31'h0, c_busy}, 32'h1);
        c_reset = 1'b1;
        step();
        c_reset = 1'b0;
        count_busy(1, n);
        chk("c_midreset_len", n, 32'd16);
        c_read("c_cleared", 4'd9, 4'd15, 4'd0, 32'h0, 32'h0, 32'h0);
        step();
        c_ren = 1'b0;

        c_write(4'd9,  32'hDEADBEEF);
        c_write(4'd15, 32'hCAFEF00D);
        c_write(4'd2,  32'h12345678);
        c_read("c_distinct", 4'd9, 4'd15, 4'd2, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678);
        step();
        c_read("c_equal", 4'd15, 4'd15, 4'd15, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
        step();
        c_wreg = 1'b1; c_wsel = 4'd7; c_wdata = 32'h0BADCAFE;
        c_read("c_bypass", 4'd7, 4'd9, 4'd7, 32'h0BADCAFE, 32'hDEADBEEF, 32'h0BADCAFE);
        step();
        c_wreg = 1'b0;
        c_ren  = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
